// File: rtl/sram_stage_sequencer.sv
// SRAM access sequencer: UART image load, then up to NUM_STAGES masked stages, then VGA readout.
// Optional per-stage watchdog is built when STAGE_WATCHDOG_EN is defined.
module sram_stage_sequencer #(
  parameter int unsigned NUM_STAGES      = 3,
  parameter int unsigned ADDR_W          = 18,
  parameter int unsigned DATA_W          = 16,
  parameter int unsigned TIMEOUT_CYCLES  = 50000000,
  parameter int unsigned WATCHDOG_CYCLES = 16777216
) (
  input  logic                         Clock_50,
  input  logic                         Resetn,
  input  logic                         Load_request,
  input  logic                         Run_request,
  input  logic [NUM_STAGES-1:0]        Stage_mask,
  output logic                         UART_initialize,
  output logic                         UART_enable,
  input  logic [ADDR_W-1:0]            UART_address,
  input  logic [DATA_W-1:0]            UART_write_data,
  input  logic                         UART_we_n,
  output logic [NUM_STAGES-1:0]        Stage_start,
  input  logic [NUM_STAGES-1:0]        Stage_finish,
  input  logic [NUM_STAGES*ADDR_W-1:0] Stage_address,
  input  logic [NUM_STAGES*DATA_W-1:0] Stage_write_data,
  input  logic [NUM_STAGES-1:0]        Stage_we_n,
  input  logic [ADDR_W-1:0]            VGA_address,
  output logic                         VGA_enable,
  output logic [ADDR_W-1:0]            SRAM_address,
  output logic [DATA_W-1:0]            SRAM_write_data,
  output logic                         SRAM_we_n,
  output logic [2:0]                   Active_stage,
  output logic [2:0]                   State_code,
  output logic                         Done,
  output logic                         Error
);

  localparam logic [2:0] S_IDLE      = 3'd0;
  localparam logic [2:0] S_UART_EN   = 3'd1;
  localparam logic [2:0] S_UART_WAIT = 3'd2;
  localparam logic [2:0] S_SELECT    = 3'd3;
  localparam logic [2:0] S_START     = 3'd4;
  localparam logic [2:0] S_RUN       = 3'd5;
  localparam logic [2:0] S_DONE      = 3'd6;

  localparam int unsigned TIMER_W = $clog2(TIMEOUT_CYCLES) + 1;
  localparam logic [TIMER_W-1:0] TIMER_MAX = TIMER_W'(TIMEOUT_CYCLES - 1);

  logic [2:0]            state_q, state_d;
  logic [NUM_STAGES-1:0] mask_q, mask_d;
  logic [TIMER_W-1:0]    timer_q;
  logic                  vga_d, uinit_d, uen_d, done_d;
  logic [2:0]            active_d;
  logic [NUM_STAGES-1:0] start_d;
  logic                  launch_c;
  logic [2:0]            launch_idx_c;
  logic                  first_found_c, next_found_c;
  logic [2:0]            first_idx_c, next_idx_c;
  logic                  fin_sel_c;
  logic [ADDR_W-1:0]     stage_addr_c;
  logic [DATA_W-1:0]     stage_data_c;
  logic                  stage_we_n_c;
  logic                  wd_expire_c;

  assign State_code = state_q;

  // Lowest enabled stage in the live mask, and next enabled stage above the active one.
  always_comb begin
    first_found_c = 1'b0;
    first_idx_c   = 3'd0;
    next_found_c  = 1'b0;
    next_idx_c    = 3'd0;
    for (int i = int'(NUM_STAGES) - 1; i >= 0; i--) begin
      if (Stage_mask[i]) begin
        first_found_c = 1'b1;
        first_idx_c   = 3'(i);
      end
      if (mask_q[i] && (i > int'(Active_stage))) begin
        next_found_c = 1'b1;
        next_idx_c   = 3'(i);
      end
    end
  end

  // Active-stage slice of the flattened client buses.
  always_comb begin
    fin_sel_c    = 1'b0;
    stage_addr_c = '0;
    stage_data_c = '0;
    stage_we_n_c = 1'b1;
    for (int i = 0; i < int'(NUM_STAGES); i++) begin
      if (Active_stage == 3'(i)) begin
        fin_sel_c    = Stage_finish[i];
        stage_addr_c = Stage_address[i*ADDR_W +: ADDR_W];
        stage_data_c = Stage_write_data[i*DATA_W +: DATA_W];
        stage_we_n_c = Stage_we_n[i];
      end
    end
  end

  always_comb begin
    SRAM_address    = VGA_address;
    SRAM_write_data = UART_write_data;
    SRAM_we_n       = 1'b1;
    case (state_q)
      S_UART_EN, S_UART_WAIT: begin
        SRAM_address    = UART_address;
        SRAM_write_data = UART_write_data;
        SRAM_we_n       = UART_we_n;
      end
      S_START, S_RUN: begin
        SRAM_address    = stage_addr_c;
        SRAM_write_data = stage_data_c;
        SRAM_we_n       = stage_we_n_c;
      end
      default: ;
    endcase
  end

  always_ff @(posedge Clock_50 or negedge Resetn) begin
    if (!Resetn) begin
      timer_q <= '0;
    end else if (UART_initialize || !UART_we_n) begin
      timer_q <= '0;
    end else if (timer_q != TIMER_MAX) begin
      timer_q <= timer_q + TIMER_W'(1);
    end
  end

`ifdef STAGE_WATCHDOG_EN
  localparam int unsigned WD_W = $clog2(WATCHDOG_CYCLES) + 1;
  localparam logic [WD_W-1:0] WD_MAX = WD_W'(WATCHDOG_CYCLES - 1);
  logic [WD_W-1:0] wd_q;

  always_ff @(posedge Clock_50 or negedge Resetn) begin
    if (!Resetn) begin
      wd_q <= '0;
    end else if (state_q == S_START) begin
      wd_q <= '0;
    end else if ((state_q == S_RUN) && (wd_q != WD_MAX)) begin
      wd_q <= wd_q + WD_W'(1);
    end
  end

  assign wd_expire_c = (wd_q == WD_MAX) && !fin_sel_c;

  // Sticky until the next accepted request.
  always_ff @(posedge Clock_50 or negedge Resetn) begin
    if (!Resetn) begin
      Error <= 1'b0;
    end else if ((state_q == S_IDLE) && (Load_request || Run_request)) begin
      Error <= 1'b0;
    end else if ((state_q == S_RUN) && wd_expire_c) begin
      Error <= 1'b1;
    end
  end
`else
  localparam int unsigned WATCHDOG_UNUSED = WATCHDOG_CYCLES;
  assign wd_expire_c = 1'b0;
  assign Error       = 1'b0;
`endif

  // Next state and registered-output values.
  always_comb begin
    state_d      = state_q;
    mask_d       = mask_q;
    active_d     = Active_stage;
    vga_d        = VGA_enable;
    uinit_d      = 1'b0;
    uen_d        = 1'b0;
    done_d       = 1'b0;
    launch_c     = 1'b0;
    launch_idx_c = Active_stage;
    case (state_q)
      S_IDLE: begin
        if (Load_request) begin
          uinit_d = 1'b1;
          vga_d   = 1'b0;
          state_d = S_UART_EN;
        end else if (Run_request) begin
          vga_d   = 1'b0;
          state_d = S_SELECT;
        end
      end
      S_UART_EN: begin
        uen_d   = 1'b1;
        state_d = S_UART_WAIT;
      end
      S_UART_WAIT: begin
        if ((timer_q == TIMER_MAX) && (UART_address != '0)) begin
          uinit_d = 1'b1;
          state_d = S_SELECT;
        end
      end
      S_SELECT: begin
        mask_d = Stage_mask;
        if (first_found_c) begin
          active_d     = first_idx_c;
          launch_c     = 1'b1;
          launch_idx_c = first_idx_c;
          state_d      = S_START;
        end else begin
          done_d  = 1'b1;
          state_d = S_DONE;
        end
      end
      S_START: begin
        state_d = S_RUN;
      end
      S_RUN: begin
        if (fin_sel_c) begin
          if (next_found_c) begin
            active_d     = next_idx_c;
            launch_c     = 1'b1;
            launch_idx_c = next_idx_c;
            state_d      = S_START;
          end else begin
            done_d  = 1'b1;
            state_d = S_DONE;
          end
        end else if (wd_expire_c) begin
          done_d  = 1'b1;
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        vga_d   = 1'b1;
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
    start_d = '0;
    for (int i = 0; i < int'(NUM_STAGES); i++) begin
      start_d[i] = launch_c && (launch_idx_c == 3'(i));
    end
  end

  always_ff @(posedge Clock_50 or negedge Resetn) begin
    if (!Resetn) begin
      state_q         <= S_IDLE;
      mask_q          <= '0;
      Active_stage    <= 3'd0;
      VGA_enable      <= 1'b1;
      UART_initialize <= 1'b0;
      UART_enable     <= 1'b0;
      Stage_start     <= '0;
      Done            <= 1'b0;
    end else begin
      state_q         <= state_d;
      mask_q          <= mask_d;
      Active_stage    <= active_d;
      VGA_enable      <= vga_d;
      UART_initialize <= uinit_d;
      UART_enable     <= uen_d;
      Stage_start     <= start_d;
      Done            <= done_d;
    end
  end

endmodule

// File: tb/tb_sram_stage_sequencer.sv
// Directed bench for sram_stage_sequencer: masked stage runs, UART load timing, arbitration, reset abort.
// The watchdog scenario is compiled in when STAGE_WATCHDOG_EN is defined.
module tb_sram_stage_sequencer;

  localparam int unsigned NS = 3;
  localparam int unsigned AW = 18;
  localparam int unsigned DW = 16;

  logic            Clock_50, Resetn, Load_request, Run_request;
  logic [NS-1:0]   Stage_mask;
  logic            UART_initialize, UART_enable;
  logic [AW-1:0]   UART_address;
  logic [DW-1:0]   UART_write_data;
  logic            UART_we_n;
  logic [NS-1:0]   Stage_start, Stage_finish, Stage_we_n;
  logic [NS*AW-1:0] Stage_address;
  logic [NS*DW-1:0] Stage_write_data;
  logic [AW-1:0]   VGA_address;
  logic            VGA_enable;
  logic [AW-1:0]   SRAM_address;
  logic [DW-1:0]   SRAM_write_data;
  logic            SRAM_we_n;
  logic [2:0]      Active_stage, State_code;
  logic            Done, Error;

  int checks = 0;
  int errors = 0;

  sram_stage_sequencer #(
    .NUM_STAGES(NS), .ADDR_W(AW), .DATA_W(DW),
    .TIMEOUT_CYCLES(20), .WATCHDOG_CYCLES(8)
  ) dut (
    .Clock_50(Clock_50), .Resetn(Resetn),
    .Load_request(Load_request), .Run_request(Run_request), .Stage_mask(Stage_mask),
    .UART_initialize(UART_initialize), .UART_enable(UART_enable),
    .UART_address(UART_address), .UART_write_data(UART_write_data), .UART_we_n(UART_we_n),
    .Stage_start(Stage_start), .Stage_finish(Stage_finish),
    .Stage_address(Stage_address), .Stage_write_data(Stage_write_data), .Stage_we_n(Stage_we_n),
    .VGA_address(VGA_address), .VGA_enable(VGA_enable),
    .SRAM_address(SRAM_address), .SRAM_write_data(SRAM_write_data), .SRAM_we_n(SRAM_we_n),
    .Active_stage(Active_stage), .State_code(State_code), .Done(Done), .Error(Error)
  );

  initial Clock_50 = 1'b0;
  always #5 Clock_50 = ~Clock_50;

  initial begin
    #2000000;
    $display("FAIL global_timeout act=running exp=finished");
    $fatal(1, "bench timeout");
  end

  typedef struct {
    logic [2:0] mask;
    int         n;
    logic [2:0] s0, s1, s2;
  } vec_t;

  task automatic step();
    @(posedge Clock_50);
    #2;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%0h exp=%0h", name, act, exp);
    end
  endtask

  function automatic logic [AW-1:0] st_addr(input int i);
    return AW'(32'h1_0100 * (i + 1));
  endfunction

  function automatic logic [DW-1:0] st_data(input int i);
    return DW'(32'hA000 + 32'h1001 * i);
  endfunction

  // Run one masked sequence; each stage finishes 5 cycles after its start pulse.
  task automatic run_vec(input vec_t v, input int id);
    logic [2:0] seen [3];
    logic [2:0] expv [3];
    int n_seen = 0, fin_cnt = -1, fin_idx = 0, cyc = 0;
    int first_cyc = -1, last_fin_cyc = -1, done_cyc = -1, done_seen = 0;
    expv[0] = v.s0; expv[1] = v.s1; expv[2] = v.s2;
    for (int k = 0; k < 3; k++) seen[k] = 3'b000;
    Stage_mask  = v.mask;
    Run_request = 1'b1;
    step();
    Run_request = 1'b0;
    cyc = 1;
    while ((done_seen == 0) && (cyc < 200)) begin
      Stage_finish = '0;
      if (fin_cnt == 0) begin
        Stage_finish[fin_idx] = 1'b1;
        last_fin_cyc = cyc;
      end
      if (fin_cnt >= 0) fin_cnt--;
      step();
      cyc++;
      if (Stage_start != '0) begin
        if (n_seen < 3) seen[n_seen] = Stage_start;
        n_seen++;
        if (first_cyc < 0) first_cyc = cyc;
        for (int i = 0; i < int'(NS); i++) if (Stage_start[i]) fin_idx = i;
        fin_cnt = 5;
        chk($sformatf("v%0d_active", id), 32'(Active_stage), 32'(fin_idx));
        chk($sformatf("v%0d_state_start", id), 32'(State_code), 32'd4);
        chk($sformatf("v%0d_sram_addr", id), 32'(SRAM_address), 32'(st_addr(fin_idx)));
        chk($sformatf("v%0d_sram_data", id), 32'(SRAM_write_data), 32'(st_data(fin_idx)));
        chk($sformatf("v%0d_sram_we", id), 32'(SRAM_we_n), 32'(Stage_we_n[fin_idx]));
        chk($sformatf("v%0d_vga_off", id), 32'(VGA_enable), 32'd0);
      end
      if (Done) begin
        done_seen = 1;
        done_cyc  = cyc;
        chk($sformatf("v%0d_state_done", id), 32'(State_code), 32'd6);
      end
    end
    Stage_finish = '0;
    chk($sformatf("v%0d_done_seen", id), 32'(done_seen), 32'd1);
    chk($sformatf("v%0d_n_starts", id), 32'(n_seen), 32'(v.n));
    for (int k = 0; k < v.n; k++)
      chk($sformatf("v%0d_start%0d", id, k), 32'(seen[k]), 32'(expv[k]));
    if (v.n > 0) begin
      chk($sformatf("v%0d_req_to_start", id), 32'(first_cyc), 32'd2);
      chk($sformatf("v%0d_fin_to_done", id), 32'(done_cyc - last_fin_cyc), 32'd1);
    end else begin
      chk($sformatf("v%0d_req_to_done", id), 32'(done_cyc), 32'd2);
    end
    step();
    chk($sformatf("v%0d_done_width", id), 32'(Done), 32'd0);
    chk($sformatf("v%0d_vga_back", id), 32'(VGA_enable), 32'd1);
    chk($sformatf("v%0d_idle", id), 32'(State_code), 32'd0);
    chk($sformatf("v%0d_error", id), 32'(Error), 32'd0);
  endtask

  task automatic wait_start(input string name, output int ok);
    int n = 0;
    ok = 0;
    while ((Stage_start == '0) && (n < 20)) begin
      step();
      n++;
    end
    if (Stage_start != '0) ok = 1;
    chk(name, 32'(ok), 32'd1);
  endtask

  initial begin
    vec_t tbl [5];
    int ok, pulses;
    tbl[0] = '{mask: 3'b111, n: 3, s0: 3'b001, s1: 3'b010, s2: 3'b100};
    tbl[1] = '{mask: 3'b101, n: 2, s0: 3'b001, s1: 3'b100, s2: 3'b000};
    tbl[2] = '{mask: 3'b010, n: 1, s0: 3'b010, s1: 3'b000, s2: 3'b000};
    tbl[3] = '{mask: 3'b110, n: 2, s0: 3'b010, s1: 3'b100, s2: 3'b000};
    tbl[4] = '{mask: 3'b000, n: 0, s0: 3'b000, s1: 3'b000, s2: 3'b000};

    Resetn = 1'b0; Load_request = 1'b0; Run_request = 1'b0; Stage_mask = '0;
    UART_address = '0; UART_write_data = 16'h5A5A; UART_we_n = 1'b1;
    Stage_finish = '0; Stage_we_n = 3'b010;
    Stage_address    = {st_addr(2), st_addr(1), st_addr(0)};
    Stage_write_data = {st_data(2), st_data(1), st_data(0)};
    VGA_address = 18'h0_0ABC;
    step(); step();
    Resetn = 1'b1;
    step();

    chk("rst_state", 32'(State_code), 32'd0);
    chk("rst_vga", 32'(VGA_enable), 32'd1);
    chk("rst_pulses", {28'd0, UART_initialize, UART_enable, Done, |Stage_start}, 32'd0);
    chk("rst_active", 32'(Active_stage), 32'd0);
    chk("rst_error", 32'(Error), 32'd0);
    chk("idle_mux_addr", 32'(SRAM_address), 32'h0_0ABC);
    chk("idle_mux_we", 32'(SRAM_we_n), 32'd1);
    chk("idle_mux_data", 32'(SRAM_write_data), 32'h5A5A);

    for (int v = 0; v < 5; v++) run_vec(tbl[v], v);

    // Foreign finish during stage 0 must not advance; mux follows stage 0.
    Stage_mask = 3'b111; Stage_we_n = 3'b010;
    Run_request = 1'b1; step(); Run_request = 1'b0;
    wait_start("arb_start0_seen", ok);
    chk("arb_start0", 32'(Stage_start), 32'b001);
    step();
    for (int k = 0; k < 6; k++) begin
      Stage_finish = 3'b010;
      #1;
      chk($sformatf("arb_we_%0d", k), 32'(SRAM_we_n), 32'd0);
      step();
      chk($sformatf("arb_hold_%0d", k), {26'd0, State_code, Active_stage}, {26'd0, 3'd5, 3'd0});
    end
    Stage_finish = '0; Stage_we_n = 3'b011;
    #1;
    chk("arb_we_follow", 32'(SRAM_we_n), 32'd1);
    Stage_finish = 3'b001;
    step();
    Stage_finish = '0;
    chk("arb_start1", 32'(Stage_start), 32'b010);
    chk("arb_active1", 32'(Active_stage), 32'd1);
    step();
    chk("arb_run1", 32'(State_code), 32'd5);

    // Asynchronous reset in the middle of stage 1.
    #1 Resetn = 1'b0;
    #1;
    chk("abort_state", 32'(State_code), 32'd0);
    chk("abort_vga", 32'(VGA_enable), 32'd1);
    chk("abort_pulses", {29'd0, Done, |Stage_start, UART_enable}, 32'd0);
    chk("abort_active", 32'(Active_stage), 32'd0);
    step();
    Resetn = 1'b1;
    pulses = 0;
    for (int k = 0; k < 10; k++) begin
      step();
      if (Done || (Stage_start != '0)) pulses++;
    end
    chk("abort_no_pulse", 32'(pulses), 32'd0);

    // UART load: mux follows UART, exit 20 cycles after the last write.
    Stage_mask = 3'b000;
    Load_request = 1'b1; Run_request = 1'b1;
    step();
    Load_request = 1'b0; Run_request = 1'b0;
    chk("uart_en_state", 32'(State_code), 32'd1);
    chk("uart_init_pulse", 32'(UART_initialize), 32'd1);
    chk("uart_vga_off", 32'(VGA_enable), 32'd0);
    step();
    chk("uart_wait_state", 32'(State_code), 32'd2);
    chk("uart_enable_pulse", {30'd0, UART_enable, UART_initialize}, 32'b10);
    for (int a = 0; a < 10; a++) begin
      UART_address = AW'(a); UART_write_data = DW'(16'hC000 + a); UART_we_n = 1'b0;
      #1;
      chk($sformatf("uart_mux_%0d", a), {SRAM_address, SRAM_we_n}, {AW'(a), 1'b0});
      chk($sformatf("uart_data_%0d", a), 32'(SRAM_write_data), 32'(16'hC000 + a));
      step();
    end
    UART_we_n = 1'b1;
    for (int j = 1; j < 20; j++) step();
    chk("uart_still_wait", 32'(State_code), 32'd2);
    step();
    chk("uart_exit_select", 32'(State_code), 32'd3);
    chk("uart_exit_init", 32'(UART_initialize), 32'd1);
    step();
    chk("uart_empty_done", 32'(Done), 32'd1);
    step();
    chk("uart_back_idle", {29'd0, State_code}, 32'd0);

`ifdef STAGE_WATCHDOG_EN
    // Stage 0 hangs: watchdog aborts the run after 8 run cycles.
    Stage_mask = 3'b111;
    Run_request = 1'b1; step(); Run_request = 1'b0;
    wait_start("wd_start0_seen", ok);
    chk("wd_start0", 32'(Stage_start), 32'b001);
    pulses = 0;
    for (int k = 0; k < 8; k++) begin
      step();
      if (Stage_start != '0) pulses++;
    end
    chk("wd_pre_state", 32'(State_code), 32'd5);
    chk("wd_pre_error", 32'(Error), 32'd0);
    step();
    chk("wd_done", 32'(Done), 32'd1);
    chk("wd_error", 32'(Error), 32'd1);
    for (int k = 0; k < 6; k++) begin
      step();
      if (Stage_start != '0) pulses++;
    end
    chk("wd_no_more_starts", 32'(pulses), 32'd0);
    chk("wd_error_sticky", 32'(Error), 32'd1);
    Stage_mask = 3'b000;
    Run_request = 1'b1; step(); Run_request = 1'b0;
    chk("wd_error_clear", 32'(Error), 32'd0);
    step(); step();
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
